// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one
// decryption round per clock while the key schedule is walked backwards.
module aes128_decrypt_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);

    typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? ({1'b0, x[7:1]} ^ 8'h8d) : {1'b0, x[7:1]};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ g_word(rk[31:0], rc);
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] prev_rk(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0] ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ g_word(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int unsigned r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                      ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
            end
        end
        return o;
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] s_q, s_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] cache_rk_q, cache_rk_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic         cache_vld_q, cache_vld_d;

    logic [127:0] rk_fwd, rk_bwd, round_in;
    logic         hit;

    assign rk_fwd   = next_rk(rk_q, rcon_q);
    assign rk_bwd   = prev_rk(rk_q, rcon_q);
    assign round_in = inv_shift_sub(s_q) ^ rk_bwd;
    assign hit      = (KEY_CACHE != 0) && cache_vld_q && (key == cache_key_q);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign pt        = pt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcon_d      = rcon_q;
        rk_d        = rk_q;
        s_d         = s_q;
        ct_d        = ct_q;
        key_d       = key_q;
        pt_d        = pt_q;
        cache_rk_d  = cache_rk_q;
        cache_key_d = cache_key_q;
        cache_vld_d = cache_vld_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ct_d  = ct;
                    key_d = key;
                    cnt_d = '0;
                    // On a hit the round-10 AddRoundKey is folded into the accept edge.
                    if (hit) begin
                        rk_d    = cache_rk_q;
                        s_d     = ct ^ cache_rk_q;
                        rcon_d  = 8'h36;
                        state_d = DEC;
                    end else begin
                        rk_d    = key;
                        rcon_d  = 8'h01;
                        state_d = KEXP;
                    end
                end
            end
            KEXP: begin
                rk_d   = rk_fwd;
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    s_d         = ct_q ^ rk_fwd;
                    rcon_d      = 8'h36;
                    cnt_d       = '0;
                    cache_rk_d  = rk_fwd;
                    cache_key_d = key_q;
                    cache_vld_d = 1'b1;
                    state_d     = DEC;
                end
            end
            DEC: begin
                rk_d   = rk_bwd;
                rcon_d = inv_xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    pt_d    = round_in;
                    state_d = DONE;
                end else begin
                    s_d = inv_mix(round_in);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rcon_q      <= '0;
            rk_q        <= '0;
            s_q         <= '0;
            ct_q        <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            cache_rk_q  <= '0;
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcon_q      <= rcon_d;
            rk_q        <= rk_d;
            s_q         <= s_d;
            ct_q        <= ct_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            cache_rk_q  <= cache_rk_d;
            cache_key_q <= cache_key_d;
            cache_vld_q <= cache_vld_d;
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS vectors, cache, backpressure, reset, and
// randomized traffic against a table-driven AES model.
module tb_aes128_decrypt_iter;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, out_ready, use_nc;
    logic [127:0] ct, key;
    logic         c_in_ready, c_out_valid, n_in_ready, n_out_valid;
    logic [127:0] c_pt, n_pt;
    logic         d_in_ready, d_out_valid;
    logic [127:0] d_pt;

    assign d_in_ready  = use_nc ? n_in_ready  : c_in_ready;
    assign d_out_valid = use_nc ? n_out_valid : c_out_valid;
    assign d_pt        = use_nc ? n_pt        : c_pt;

    aes128_decrypt_iter #(.KEY_CACHE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !use_nc), .in_ready(c_in_ready),
        .ct(ct), .key(key), .out_valid(c_out_valid), .out_ready(out_ready && !use_nc), .pt(c_pt)
    );

    aes128_decrypt_iter #(.KEY_CACHE(0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && use_nc), .in_ready(n_in_ready),
        .ct(ct), .key(key), .out_valid(n_out_valid), .out_ready(out_ready && use_nc), .pt(n_pt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] m_rk    [11];

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        int x, y, p;
        x = int'(a);
        y = int'(b);
        p = 0;
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] byt(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    task automatic m_build_tables();
        logic [7:0] inv, b, cc;
        cc = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cc[i];
            sbox_t[x]  = b;
            isbox_t[b] = 8'(x);
        end
    endtask

    task automatic m_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]] ^ rc, sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic m_encrypt(input logic [127:0] k, input logic [127:0] p, output logic [127:0] c);
        logic [7:0] st [16];
        logic [7:0] t  [16];
        m_expand(k);
        for (int i = 0; i < 16; i++) st[i] = byt(p, i) ^ byt(m_rk[0], i);
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
            for (int cl = 0; cl < 4; cl++)
                for (int rw = 0; rw < 4; rw++) t[rw+4*cl] = st[rw+4*((cl+rw)%4)];
            for (int cl = 0; cl < 4; cl++)
                for (int rw = 0; rw < 4; rw++)
                    st[rw+4*cl] = (r == 10) ? t[rw+4*cl] :
                        m_mul(t[4*cl+rw], 8'h02) ^ m_mul(t[4*cl+(rw+1)%4], 8'h03)
                        ^ t[4*cl+(rw+2)%4] ^ t[4*cl+(rw+3)%4];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ byt(m_rk[r], i);
        end
        for (int i = 0; i < 16; i++) c[127-8*i -: 8] = st[i];
    endtask

    task automatic m_decrypt(input logic [127:0] k, input logic [127:0] c, output logic [127:0] p);
        logic [7:0] st [16];
        logic [7:0] t  [16];
        m_expand(k);
        for (int i = 0; i < 16; i++) st[i] = byt(c, i) ^ byt(m_rk[10], i);
        for (int r = 9; r >= 0; r--) begin
            for (int cl = 0; cl < 4; cl++)
                for (int rw = 0; rw < 4; rw++) t[rw+4*cl] = isbox_t[st[rw+4*((cl-rw+4)%4)]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ byt(m_rk[r], i);
            for (int cl = 0; cl < 4; cl++)
                for (int rw = 0; rw < 4; rw++)
                    st[rw+4*cl] = (r == 0) ? t[rw+4*cl] :
                        m_mul(t[4*cl+rw], 8'h0e) ^ m_mul(t[4*cl+(rw+1)%4], 8'h0b)
                        ^ m_mul(t[4*cl+(rw+2)%4], 8'h0d) ^ m_mul(t[4*cl+(rw+3)%4], 8'h09);
        end
        for (int i = 0; i < 16; i++) p[127-8*i -: 8] = st[i];
    endtask

    // One block through the selected DUT; optionally holds out_ready low for
    // `hold` cycles while poking in_valid with junk.
    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] c,
                             input logic [127:0] exp, input int exp_lat, input int hold);
        int g, n;
        g = 0;
        while (!d_in_ready && g < 50) begin tick(); g++; end
        check_eq({tag, "_in_ready"}, 128'(d_in_ready), 128'd1);
        ct = c; key = k; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ct  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!d_out_valid && n < 100) begin tick(); n++; end
        check_eq({tag, "_latency"}, 128'(n), 128'(exp_lat));
        check_eq({tag, "_pt"}, d_pt, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2 == 0);
            ct  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check_eq({tag, "_hold_pt"}, d_pt, exp);
            check_eq({tag, "_hold_ov"}, 128'(d_out_valid), 128'd1);
            check_eq({tag, "_hold_ir"}, 128'(d_in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_post_ov"}, 128'(d_out_valid), 128'd0);
        check_eq({tag, "_post_ir"}, 128'(d_in_ready), 128'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] e3;
        logic [127:0] expq [$];
        m_build_tables();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_nc = 1'b0; ct = '0; key = '0;
        repeat (3) tick();
        check_eq("rst_in_ready", 128'(c_in_ready), 128'd1);
        check_eq("rst_out_valid", 128'(c_out_valid), 128'd0);
        check_eq("rst_pt", c_pt, '0);
        rst_n = 1'b1;
        tick();

        m_decrypt(KEY2, CT1, e3);
        run_block("t1", KEY1, CT1, PT1, 20, 0);
        run_block("t2", KEY2, CT2, PT2, 20, 0);
        run_block("t3_hit", KEY2, CT1, e3, 10, 0);

        use_nc = 1'b1;
        run_block("t3_nc_a", KEY2, CT2, PT2, 20, 0);
        run_block("t3_nc_b", KEY2, CT1, e3, 20, 0);
        use_nc = 1'b0;

        run_block("t4", KEY2, CT2, PT2, 10, 7);

        ct = CT1; key = KEY1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("t5_out_valid", 128'(c_out_valid), 128'd0);
        check_eq("t5_pt", c_pt, '0);
        check_eq("t5_in_ready", 128'(c_in_ready), 128'd1);
        run_block("t5_after", KEY1, CT1, PT1, 20, 0);
        run_block("t5_rehit", KEY1, CT1, PT1, 10, 0);

        fork
            begin : producer
                logic [127:0] k, prev_k, p, c;
                int g;
                prev_k = KEY1;
                for (int b = 0; b < 200; b++) begin
                    k = ($urandom_range(0, 3) == 0) ? prev_k : {$urandom, $urandom, $urandom, $urandom};
                    p = {$urandom, $urandom, $urandom, $urandom};
                    m_encrypt(k, p, c);
                    expq.push_back(p);
                    prev_k = k;
                    g = 0;
                    while (!d_in_ready && g < 500) begin tick(); g++; end
                    if (!d_in_ready) check_eq("t6_in_ready_timeout", 128'(d_in_ready), 128'd1);
                    ct = c; key = k; in_valid = 1'b1;
                    tick();
                    in_valid = 1'b0;
                end
            end
            begin : consumer
                int got, cyc;
                logic [127:0] e;
                got = 0;
                cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    if (d_out_valid && out_ready) begin
                        e = (expq.size() > 0) ? expq.pop_front() : '1;
                        check_eq("t6_pt", d_pt, e);
                        got++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
                check_eq("t6_count", 128'(got), 128'd200);
            end
        join
        check_eq("t6_queue_empty", 128'(expq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
